// File: rtl/ay_envelope_generator.sv
// AY-3-8913 envelope generator: prescaled period counter driving a 4-bit
// step counter with invert/hold control taken from the R13 shape bits.
module ay_envelope_generator #(
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    input  logic [PERIOD_BITS-1:0]   period,
    input  logic                     continue_,
    input  logic                     attack,
    input  logic                     alternate,
    input  logic                     hold,
    output logic [ENVELOPE_BITS-1:0] out,
    output logic                     holding
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = 1;
    localparam logic [PERIOD_BITS-1:0]   PER_ONE  = 1;
    localparam logic [ENVELOPE_BITS-1:0] STEP_ONE = 1;

    logic [PRESCALE_BITS-1:0] pre_q, pre_d;
    logic [PERIOD_BITS-1:0]   cnt_q, cnt_d;
    logic [ENVELOPE_BITS-1:0] step_q, step_d;
    logic                     inv_q, inv_d;
    logic                     holding_q, holding_d;

    logic                     tick;
    logic                     step_ev;
    logic [PERIOD_BITS-1:0]   per_m1;

    // Tick and step-event detection; period 0 is treated as 1, and >=
    // keeps a lowered period from forcing a full counter wrap.
    always_comb begin
        tick    = &pre_q;
        per_m1  = (period == '0) ? '0 : period - PER_ONE;
        step_ev = tick && (cnt_q >= per_m1);
    end

    // Next-state: restart overrides stepping; end-of-cycle shape rules.
    always_comb begin
        pre_d     = pre_q + PRE_ONE;
        cnt_d     = cnt_q;
        step_d    = step_q;
        inv_d     = inv_q;
        holding_d = holding_q;
        if (restart) begin
            pre_d     = '0;
            cnt_d     = '0;
            step_d    = '0;
            inv_d     = ~attack;
            holding_d = 1'b0;
        end else begin
            if (tick) begin
                cnt_d = step_ev ? '0 : cnt_q + PER_ONE;
            end
            if (step_ev && !holding_q) begin
                if (step_q != '1) begin
                    step_d = step_q + STEP_ONE;
                end else if (!continue_) begin
                    holding_d = 1'b1;
                    inv_d     = 1'b1;
                end else if (hold) begin
                    holding_d = 1'b1;
                    inv_d     = inv_q ^ alternate;
                end else begin
                    step_d = '0;
                    inv_d  = inv_q ^ alternate;
                end
            end
        end
    end

    // State registers; reset parks the block frozen at level 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            step_q    <= '1;
            inv_q     <= 1'b1;
            holding_q <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            inv_q     <= inv_d;
            holding_q <= holding_d;
        end
    end

    assign out     = step_q ^ {ENVELOPE_BITS{inv_q}};
    assign holding = holding_q;

endmodule
